array_sequencer: RTL and testbench

ARRAY_SEQUENCER -- requirements
Module: array_sequencer

---
 rtl/array_sequencer_pkg.sv | 18 +
 rtl/array_sequencer_skew.sv | 37 +++
 rtl/array_sequencer.sv | 123 ++++++++++++
 tb/tb_array_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/array_sequencer_pkg.sv
// array_sequencer_pkg
//   Shared sizing and state encoding for the systolic-array operand sequencer.
//   N        : array edge length (lanes on each of the west and north edges)
//   NUM_BITS : operand width
//   seq_state_t : job-level state of the sequencer
package array_sequencer_pkg;

  localparam int N        = 4;
  localparam int NUM_BITS = 8;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} seq_state_t;

  // Bit width for a value range 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/array_sequencer_skew.sv
// skew_delay
//   Per-lane operand delay line: DEPTH registered stages with a synchronous
//   clear. DEPTH = 0 degenerates to a wire.
//   clk_i : clock
//   clr_i : synchronous clear of every stage
//   d_i   : lane input
//   q_o   : lane output, d_i delayed DEPTH cycles
module skew_delay #(
  parameter int DEPTH    = 1,
  parameter int NUM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic [NUM_BITS-1:0] d_i,
  output logic [NUM_BITS-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk_i, clr_i};
    assign q_o = d_i;
  end else begin : g_sr
    logic [DEPTH-1:0][NUM_BITS-1:0] sr;

    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        sr <= '0;
      end else begin
        sr[0] <= d_i;
        for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
      end
    end

    assign q_o = sr[DEPTH-1];
  end

endmodule

// File: rtl/array_sequencer.sv
// array_sequencer
//   Streams K_DEPTH columns of A and rows of B out of the operand buffers,
//   skews them onto the west/north edges of an N x N systolic array and
//   strobes each column's accumulator when its inner product is complete.
//   Optional feature (macro SEQ_ABORT_EN): abort_i input cancels a running job.
//
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : job request, taken only in IDLE
//   abort_i                 : (SEQ_ABORT_EN only) cancel job in FEED/DRAIN
//   busy_o, done_o          : job in flight / one-cycle completion pulse
//   a_rd_en_o, b_rd_en_o    : operand buffer read strobes
//   rd_addr_o               : shared read index k
//   a_rd_data_i, b_rd_data_i: A column k / B row k, one cycle after strobe
//   left_o, top_o           : skewed west / north edge operands
//   acc_valid_o             : per-column accumulator capture strobe
module array_sequencer
  import array_sequencer_pkg::*;
#(
  parameter  int K_DEPTH = N,
  localparam int ADDR_W  = clog2_min1(K_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
`ifdef SEQ_ABORT_EN
  input  logic                         abort_i,
`endif
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         a_rd_en_o,
  output logic                         b_rd_en_o,
  output logic [ADDR_W-1:0]            rd_addr_o,
  input  logic [N-1:0][NUM_BITS-1:0]   a_rd_data_i,
  input  logic [N-1:0][NUM_BITS-1:0]   b_rd_data_i,
  output logic [N-1:0][NUM_BITS-1:0]   left_o,
  output logic [N-1:0][NUM_BITS-1:0]   top_o,
  output logic [N-1:0]                 acc_valid_o
);

  // cnt = cycles since acceptance minus one; spans 0..K_DEPTH+2N-1.
  localparam int CNT_W = clog2_min1(K_DEPTH + 2*N);
  localparam int LAST  = K_DEPTH + 2*N - 1;

  seq_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic rd_vld;      // buffer data on the inputs this cycle belongs to the job
  logic abort_hit;
  logic flush;

`ifdef SEQ_ABORT_EN
  assign abort_hit = abort_i && ((state == FEED) || (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif
  assign flush = rst_i | abort_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rd_vld <= a_rd_en_o & ~abort_hit;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_o      = (state != IDLE);
    done_o      = (state == DONE);
    a_rd_en_o   = 1'b0;
    rd_addr_o   = '0;
    acc_valid_o = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_i) state_nxt = FEED;
      end
      FEED: begin
        a_rd_en_o = 1'b1;
        rd_addr_o = cnt[ADDR_W-1:0];
        cnt_nxt   = cnt + 1'b1;
        if (cnt == CNT_W'(K_DEPTH - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(LAST)) state_nxt = DONE;
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Column j's last product term leaves the array N+j cycles after the
    // final read's data arrives.
    for (int j = 0; j < N; j++)
      acc_valid_o[j] = (state == DRAIN) && (cnt == CNT_W'(K_DEPTH + N + j));
    if (abort_hit) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
    b_rd_en_o = a_rd_en_o;
  end

  // Stale buffer outputs are masked so the edges carry zero between jobs.
  logic [N-1:0][NUM_BITS-1:0] a_in, b_in;
  assign a_in = rd_vld ? a_rd_data_i : '0;
  assign b_in = rd_vld ? b_rd_data_i : '0;

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_delay #(.DEPTH(g), .NUM_BITS(NUM_BITS)) u_skew_a (
      .clk_i (clk_i), .clr_i (flush), .d_i (a_in[g]), .q_o (left_o[g])
    );
    skew_delay #(.DEPTH(g), .NUM_BITS(NUM_BITS)) u_skew_b (
      .clk_i (clk_i), .clr_i (flush), .d_i (b_in[g]), .q_o (top_o[g])
    );
  end

endmodule

// File: tb/tb_array_sequencer.sv
module tb_array_sequencer;
  import array_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // dut0: K_DEPTH = 4, dut1: K_DEPTH = 1
  logic st0 = 0, st1 = 0, rs0 = 0, rs1 = 0, ab0 = 0, ab1 = 0;
  logic [N-1:0][NUM_BITS-1:0] ad0 = '0, bd0 = '0, ad1 = '0, bd1 = '0;
  logic bz0, dn0, ae0, be0, bz1, dn1, ae1, be1;
  logic [1:0] addr0;
  logic [0:0] addr1;
  logic [N-1:0][NUM_BITS-1:0] lf0, tp0, lf1, tp1;
  logic [N-1:0] av0, av1;

  array_sequencer #(.K_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rs0), .start_i(st0),
`ifdef SEQ_ABORT_EN
    .abort_i(ab0),
`endif
    .busy_o(bz0), .done_o(dn0), .a_rd_en_o(ae0), .b_rd_en_o(be0),
    .rd_addr_o(addr0), .a_rd_data_i(ad0), .b_rd_data_i(bd0),
    .left_o(lf0), .top_o(tp0), .acc_valid_o(av0));

  array_sequencer #(.K_DEPTH(1)) dut1 (
    .clk_i(clk), .rst_i(rs1), .start_i(st1),
`ifdef SEQ_ABORT_EN
    .abort_i(ab1),
`endif
    .busy_o(bz1), .done_o(dn1), .a_rd_en_o(ae1), .b_rd_en_o(be1),
    .rd_addr_o(addr1), .a_rd_data_i(ad1), .b_rd_data_i(bd1),
    .left_o(lf1), .top_o(tp1), .acc_valid_o(av1));

  // Reference model: each DUT is described by the acceptance cycle of its
  // live job and that job's operand matrices; outputs follow from timing
  // formulas relative to that cycle.
  int   kd[2] = '{4, 1};
  int   t0[2];
  bit   job[2] = '{0, 0};
  bit   known[2] = '{0, 0};
  bit   pat_used = 0;
  logic [7:0] am[2][N][4];   // am[d][i][k] = A[i][k]
  logic [7:0] bm[2][4][N];   // bm[d][k][j] = B[k][j]
  bit   prd[2] = '{0, 0};
  int   padr[2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d obs=%0h exp=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic bz, dn, ae, be;
    logic [31:0] adr;
    logic [N-1:0][NUM_BITS-1:0] lf, tp;
    logic [N-1:0] av, e_av;
    int t, k, L, e_adr;
    bit act, e_rd;
    if (d == 0) begin
      bz = bz0; dn = dn0; ae = ae0; be = be0; adr = 32'(addr0);
      lf = lf0; tp = tp0; av = av0;
    end else begin
      bz = bz1; dn = dn1; ae = ae1; be = be1; adr = 32'(addr1);
      lf = lf1; tp = tp1; av = av1;
    end
    if (known[d]) begin
      k = kd[d];
      L = k + 2*N + 1;
      t = cyc - t0[d];
      act = job[d] && t >= 1 && t <= L;
      e_rd = act && t <= k;
      e_adr = e_rd ? t - 1 : 0;
      chk("busy", d, 32'(bz), 32'(act));
      chk("done", d, 32'(dn), 32'(act && t == L));
      chk("a_rd_en", d, 32'(ae), 32'(e_rd));
      chk("b_rd_en", d, 32'(be), 32'(e_rd));
      chk("rd_addr", d, adr, 32'(e_adr));
      for (int i = 0; i < N; i++) begin
        int kk;
        kk = t - 2 - i;
        chk($sformatf("left%0d", i), d, 32'(lf[i]),
            (act && kk >= 0 && kk < k) ? 32'(am[d][i][kk]) : 32'd0);
        chk($sformatf("top%0d", i), d, 32'(tp[i]),
            (act && kk >= 0 && kk < k) ? 32'(bm[d][kk][i]) : 32'd0);
      end
      e_av = '0;
      for (int j = 0; j < N; j++) e_av[j] = act && (t == k + N + 1 + j);
      chk("acc_valid", d, 32'(av), 32'(e_av));
    end
    prd[d] = (ae === 1'b1);
    padr[d] = int'(adr);
  endtask

  task automatic update_model(input int d, input bit s, input bit r, input bit a);
    int t, L;
    t = cyc - t0[d];
    L = kd[d] + 2*N + 1;
    if (r) begin
      known[d] = 1;
      job[d] = 0;
    end else if (a && job[d] && t >= 1 && t <= L - 1) begin
      job[d] = 0;
    end else if (s && known[d] && (!job[d] || t > L)) begin
      job[d] = 1;
      t0[d] = cyc;
      for (int i = 0; i < N; i++)
        for (int kk = 0; kk < 4; kk++) begin
          if (d == 0 && !pat_used) begin
            am[d][i][kk] = 8'(16*i + kk);
            bm[d][kk][i] = 8'(16*kk + i);
          end else begin
            am[d][i][kk] = 8'($urandom);
            bm[d][kk][i] = 8'($urandom);
          end
        end
      if (d == 0) pat_used = 1;
    end
  endtask

  // One clock cycle: buffer responses, control inputs, checks, model update.
  task automatic step(input bit s0, input bit r0, input bit a0,
                      input bit s1, input bit r1, input bit a1);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      ad0[i] = prd[0] ? am[0][i][padr[0]] : 8'($urandom);
      bd0[i] = prd[0] ? bm[0][padr[0]][i] : 8'($urandom);
      ad1[i] = prd[1] ? am[1][i][padr[1]] : 8'($urandom);
      bd1[i] = prd[1] ? bm[1][padr[1]][i] : 8'($urandom);
    end
    st0 = s0; rs0 = r0; ab0 = a0;
    st1 = s1; rs1 = r1; ab1 = a1;
    #1;
    check_dut(0);
    check_dut(1);
    if (cyc == 15) chk("left2_0x21", 0, 32'(lf0[2]), 32'h21);
    if (cyc == 18) chk("top3_0x33", 0, 32'(tp0[3]), 32'h33);
    if (cyc == 19) chk("acc_first", 0, 32'(av0), 32'h1);
    if (cyc == 22) chk("acc_last", 0, 32'(av0), 32'h8);
    if (cyc == 23) chk("done_23", 0, 32'(dn0), 32'h1);
    if (cyc == 24) chk("busy_low_24", 0, 32'(bz0), 32'h0);
    if (cyc == 25) chk("job2_read_25", 0, 32'(ae0), 32'h1);
    if (cyc == 55) chk("rst_left_55", 0, 32'(lf0), 32'h0);
    if (cyc == 6)  chk("k1_read_6", 1, 32'(ae1), 32'h1);
    if (cyc == 11) chk("k1_acc0_11", 1, 32'(av1), 32'h1);
    if (cyc == 15) chk("k1_done_15", 1, 32'(dn1), 32'h1);
    update_model(0, s0, r0, a0);
    update_model(1, s1, r1, a1);
  endtask

  bit ab_en;

  initial begin
`ifdef SEQ_ABORT_EN
    ab_en = 1;
`else
    ab_en = 0;
`endif
    // Reset both instances.
    repeat (3) step(0, 1, 0, 0, 1, 0);
    // K_DEPTH=1 job accepted at cycle 5; K_DEPTH=4 start held high 10..30,
    // so the second job is taken in the first IDLE cycle after DONE.
    while (cyc < 30) step(cyc + 1 >= 10, 0, 0, cyc + 1 == 5, 0, 0);
    // Reset in the middle of FEED.
    while (cyc < 65) step(cyc + 1 == 50, cyc + 1 == 54, 0, 0, 0, 0);
    // Abort during DRAIN (only has an effect with the abort feature).
    while (cyc < 90) step(cyc + 1 == 70, 0, ab_en && cyc + 1 == 77, 0, 0, 0);
    // Random traffic on both instances.
    repeat (400)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0,
           ab_en && $urandom_range(0, 25) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0,
           ab_en && $urandom_range(0, 25) == 0);
    repeat (30) step(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
